// File: rtl/multiport_register_file.sv
// Integer register file with N read / M write ports, same-cycle forwarding,
// optional hardwired r0 and a per-register busy scoreboard for issue.
module multiport_register_file #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_PORTS    = 2,
  parameter int WRITE_PORTS   = 1,
  parameter int ZERO_REG      = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] read_id,
  output logic [READ_PORTS*DATA_WIDTH-1:0]    read_data,
  output logic [READ_PORTS-1:0]               read_busy,
  input  logic [WRITE_PORTS-1:0]              write_en,
  input  logic [WRITE_PORTS*ADDRESS_WIDTH-1:0] write_id,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0]   write_data,
  input  logic                                reserve_en,
  input  logic [ADDRESS_WIDTH-1:0]            reserve_id,
  output logic                                any_busy
);

  localparam int AW    = ADDRESS_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             any_busy_q;

  // Writes clear, reserve sets afterwards so a back-to-back producer stays busy.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      if (write_en[j]) begin
        busy_d[write_id[j*AW +: AW]] = 1'b0;
      end
    end
    if (reserve_en) begin
      busy_d[reserve_id] = 1'b1;
    end
    if (HAS_ZERO) begin
      busy_d[0] = 1'b0;
    end
  end

  // Ascending port order: the highest-indexed port wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      busy_q     <= '0;
      any_busy_q <= 1'b0;
    end else begin
      for (int j = 0; j < WRITE_PORTS; j++) begin
        if (write_en[j] &&
            !(HAS_ZERO && (write_id[j*AW +: AW] == '0))) begin
          mem_q[write_id[j*AW +: AW]] <= write_data[j*DW +: DW];
        end
      end
      busy_q     <= busy_d;
      any_busy_q <= |busy_d;
    end
  end

  assign any_busy = any_busy_q;

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
    logic [AW-1:0] rid;
    logic [DW-1:0] rdata;
    logic          rbusy;

    assign rid = read_id[gi*AW +: AW];

    always_comb begin
      rdata = mem_q[rid];
      rbusy = busy_q[rid];
      for (int j = 0; j < WRITE_PORTS; j++) begin
        if (write_en[j] && (write_id[j*AW +: AW] == rid)) begin
          rdata = write_data[j*DW +: DW];
          rbusy = 1'b0;
        end
      end
      if ((HAS_ZERO && (rid == '0)) || rst) begin
        rdata = '0;
        rbusy = 1'b0;
      end
    end

    assign read_data[gi*DW +: DW] = rdata;
    assign read_busy[gi]          = rbusy;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file: 2 read / 2 write ports, r0 hardwired.
module tb_multiport_register_file;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RP = 2;
  localparam int WP = 2;

  logic              clk;
  logic              rst;
  logic [RP*AW-1:0]  read_id;
  logic [RP*DW-1:0]  read_data;
  logic [RP-1:0]     read_busy;
  logic [WP-1:0]     write_en;
  logic [WP*AW-1:0]  write_id;
  logic [WP*DW-1:0]  write_data;
  logic              reserve_en;
  logic [AW-1:0]     reserve_id;
  logic              any_busy;

  int n_chk;
  int n_err;

  multiport_register_file #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .READ_PORTS   (RP),
    .WRITE_PORTS  (WP),
    .ZERO_REG     (1)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .read_id   (read_id),
    .read_data (read_data),
    .read_busy (read_busy),
    .write_en  (write_en),
    .write_id  (write_id),
    .write_data(write_data),
    .reserve_en(reserve_en),
    .reserve_id(reserve_id),
    .any_busy  (any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return read_data[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rb(input int p);
    return {31'd0, read_busy[p]};
  endfunction

  function automatic logic [DW-1:0] ab();
    return {31'd0, any_busy};
  endfunction

  task automatic set_rd(input int p, input logic [AW-1:0] id);
    read_id[p*AW +: AW] = id;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] id,
                    input logic [DW-1:0] d);
    write_en[p]            = 1'b1;
    write_id[p*AW +: AW]   = id;
    write_data[p*DW +: DW] = d;
  endtask

  task automatic rsv(input logic [AW-1:0] id);
    reserve_en = 1'b1;
    reserve_id = id;
  endtask

  task automatic idle();
    write_en   = '0;
    reserve_en = 1'b0;
  endtask

  // Advance one edge, then leave time for combinational settle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst        = 1'b1;
    read_id    = '0;
    write_id   = '0;
    write_data = '0;
    idle();

    // Write and reserve during reset must be ignored; outputs forced to 0.
    wr(0, 5'd5, 32'hDEADBEEF);
    rsv(5'd5);
    set_rd(0, 5'd5);
    settle();
    chk("rst_fwd_data", rd(0), 32'h0);
    chk("rst_busy", rb(0), 32'h0);
    step();
    rst = 1'b0;
    set_rd(0, 5'd5);
    settle();
    chk("post_rst_data", rd(0), 32'h0);
    chk("post_rst_busy", rb(0), 32'h0);
    chk("post_rst_any", ab(), 32'h0);

    // Same-cycle forwarding then stored value.
    wr(0, 5'd7, 32'h12345678);
    set_rd(1, 5'd7);
    settle();
    chk("fwd_same", rd(1), 32'h12345678);
    chk("fwd_other", rd(0), 32'h0);
    step();
    settle();
    chk("fwd_stored", rd(1), 32'h12345678);

    // Collision: port 1 wins.
    wr(0, 5'd3, 32'h1111);
    wr(1, 5'd3, 32'h2222);
    set_rd(0, 5'd3);
    settle();
    chk("coll_fwd", rd(0), 32'h2222);
    step();
    settle();
    chk("coll_stored", rd(0), 32'h2222);

    // Distinct indices on one edge both land.
    wr(0, 5'd10, 32'hAAAA0010);
    wr(1, 5'd11, 32'hBBBB0011);
    set_rd(0, 5'd10);
    set_rd(1, 5'd11);
    settle();
    chk("dual_fwd0", rd(0), 32'hAAAA0010);
    chk("dual_fwd1", rd(1), 32'hBBBB0011);
    step();
    settle();
    chk("dual_st0", rd(0), 32'hAAAA0010);
    chk("dual_st1", rd(1), 32'hBBBB0011);

    // Zero register.
    wr(1, 5'd0, 32'hFFFFFFFF);
    rsv(5'd0);
    set_rd(0, 5'd0);
    settle();
    chk("zero_fwd", rd(0), 32'h0);
    step();
    settle();
    chk("zero_data", rd(0), 32'h0);
    chk("zero_busy", rb(0), 32'h0);
    chk("zero_any", ab(), 32'h0);

    // Scoreboard: reserve r9 at edge N.
    rsv(5'd9);
    set_rd(0, 5'd9);
    settle();
    chk("sb_rsv_same", rb(0), 32'h0);
    step();
    settle();
    chk("sb_busy_n1", rb(0), 32'h1);
    chk("sb_any_n1", ab(), 32'h1);
    step();
    settle();
    chk("sb_busy_n2", rb(0), 32'h1);
    step();
    wr(0, 5'd9, 32'hAB);
    settle();
    chk("sb_wr_busy", rb(0), 32'h0);
    chk("sb_wr_any", ab(), 32'h1);
    chk("sb_wr_fwd", rd(0), 32'hAB);
    step();
    settle();
    chk("sb_clr_any", ab(), 32'h0);
    chk("sb_clr_busy", rb(0), 32'h0);
    chk("sb_clr_data", rd(0), 32'hAB);

    // Set beats clear on r4 while r4 busy.
    rsv(5'd4);
    set_rd(1, 5'd4);
    step();
    settle();
    chk("sbc_pre_busy", rb(1), 32'h1);
    wr(0, 5'd4, 32'h55);
    rsv(5'd4);
    settle();
    chk("sbc_same_busy", rb(1), 32'h0);
    step();
    settle();
    chk("sbc_data", rd(1), 32'h55);
    chk("sbc_busy", rb(1), 32'h1);
    chk("sbc_any", ab(), 32'h1);

    // Two busy regs: clearing one keeps any_busy high.
    rsv(5'd12);
    step();
    wr(1, 5'd4, 32'h66);
    step();
    settle();
    chk("two_any", ab(), 32'h1);
    chk("two_r4_busy", rb(1), 32'h0);
    wr(0, 5'd12, 32'h12);
    step();
    settle();
    chk("two_any_clr", ab(), 32'h0);

    // Reset mid-run clears stored data and busy.
    rsv(5'd20);
    step();
    rst = 1'b1;
    set_rd(0, 5'd10);
    settle();
    chk("rst2_force", rd(0), 32'h0);
    step();
    rst = 1'b0;
    set_rd(1, 5'd20);
    settle();
    chk("rst2_data", rd(0), 32'h0);
    chk("rst2_busy", rb(1), 32'h0);
    chk("rst2_any", ab(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
